// File: rtl/dt1_pkg.sv
// Shared RV32I data-memory definitions: decoder size codes, LSU FSM states,
// load context and access-width helper.
package dt1_pkg;

  localparam logic [1:0] SW  = 2'b01;
  localparam logic [1:0] SH  = 2'b10;
  localparam logic [1:0] SB  = 2'b11;

  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LB  = 3'b001;
  localparam logic [2:0] LBU = 3'b010;
  localparam logic [2:0] LH  = 3'b011;
  localparam logic [2:0] LHU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } acc_size_t;

  typedef struct packed {
    logic       is_load;
    logic [2:0] size;
    logic [1:0] off;
  } ld_ctx_t;

  // A pending store overrides the load size; unknown load codes act as lw.
  function automatic acc_size_t acc_size(input logic [1:0] mem_write,
                                         input logic [2:0] load_size);
    acc_size_t sz;
    sz = SZ_WORD;
    if (mem_write != 2'b00) begin
      case (mem_write)
        SH:      sz = SZ_HALF;
        SB:      sz = SZ_BYTE;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (load_size)
        LB, LBU: sz = SZ_BYTE;
        LH, LHU: sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/dt1_load_ext.sv
// Load lane select and sign/zero extension of the returned bus word.
module dt1_load_ext (
  input  logic [31:0] bus_rdata,
  input  logic [2:0]  load_size,
  input  logic [1:0]  off,
  output logic [31:0] result
);
  import dt1_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  assign b = bus_rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    case (load_size)
      LB:      result = {{24{b[7]}}, b};
      LBU:     result = {24'h0, b};
      LH:      result = {{16{h[15]}}, h};
      LHU:     result = {16'h0, h};
      default: result = bus_rdata;
    endcase
  end

endmodule

// File: rtl/dt1_lsu_ctrl.sv
// MEM-stage load/store sequencer: one word-aligned handshaked bus cycle per
// access, pipeline stall until ack, misalign and timeout reporting.
module dt1_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [1:0]  mem_write,
  input  logic [2:0]  load_size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  import dt1_pkg::*;

  localparam logic [7:0] TMO = TIMEOUT_CYCLES[7:0];

  lsu_state_t  state, state_nxt;
  logic [7:0]  tmo_cnt;
  logic        is_store, is_load, pending, mis, tmo_hit;
  acc_size_t   sz;
  logic [3:0]  be;
  logic [31:0] wd, ext;
  ld_ctx_t     ld_q;

  assign is_store = mem_write != 2'b00;
  assign is_load  = load_en && !is_store;
  assign pending  = is_store || load_en;
  assign sz       = acc_size(mem_write, load_size);
  assign tmo_hit  = tmo_cnt == TMO;

  always_comb begin
    mis = 1'b0;
    be  = 4'b1111;
    case (sz)
      SZ_HALF: begin
        mis = addr[0];
        be  = 4'b0011 << {addr[1], 1'b0};
      end
      SZ_BYTE: be = 4'b0001 << addr[1:0];
      default: mis = addr[1:0] != 2'b00;
    endcase
  end

  always_comb begin
    wd = 32'h0;
    case (mem_write)
      SW:      wd = wdata;
      SH:      wd = {2{wdata[15:0]}};
      SB:      wd = {4{wdata[7:0]}};
      default: wd = 32'h0;
    endcase
  end

  dt1_load_ext u_ext (
    .bus_rdata (bus_rdata),
    .load_size (ld_q.size),
    .off       (ld_q.off),
    .result    (ext)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        stall = pending;
        if (pending) state_nxt = mis ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        stall = 1'b1;
        if (bus_ack || tmo_hit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are held for the whole BUSY window and cleared on exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      rdata     <= 32'h0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      tmo_cnt   <= 8'h0;
      ld_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (pending) begin
          if (mis) begin
            misalign <= 1'b1;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_be    <= be;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= wd;
            ld_q      <= '{is_load: is_load, size: load_size, off: addr[1:0]};
            tmo_cnt   <= 8'h0;
          end
        end
        S_BUSY: begin
          if (bus_ack || tmo_hit) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'h0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            if (bus_ack) rdata <= ld_q.is_load ? ext : 32'h0;
            else         bus_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_DONE: begin
          rdata    <= 32'h0;
          misalign <= 1'b0;
          bus_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
